// File: rtl/mlp_accel_pkg.sv
// Shared definitions for the MLP dot-product accelerator.
// Mode bit positions, accumulator FSM states and width helpers.
package mlp_accel_pkg;

    localparam int MODE_RELU = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } acc_state_e;

    // Width of the lane-product reduction including growth bits.
    function automatic int tree_w(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

endpackage

// File: rtl/mlp_adder_tree.sv
// Signed reduction of LANES packed products into one sum.
// Each term is sign-extended to the full output width first.
module mlp_adder_tree #(
    parameter int LANES = 4,
    parameter int IW    = 16,
    parameter int OW    = IW + $clog2(LANES)
) (
    input  logic [LANES*IW-1:0] p_i,
    output logic [OW-1:0]       sum_o
);

    logic signed [OW-1:0] acc;
    logic signed [IW-1:0] term;

    // Sum all sign-extended lane products.
    always_comb begin
        acc  = '0;
        term = '0;
        for (int i = 0; i < LANES; i++) begin
            term = p_i[i*IW +: IW];
            acc  = acc + OW'(term);
        end
    end

    assign sum_o = acc;

endmodule

// File: rtl/mlp_dot_accel.sv
// Multi-lane signed dot-product/accumulate engine.
// S1 multiply, S2 reduce, S3 accumulate with ReLU/saturation.
module mlp_dot_accel
    import mlp_accel_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 32,
    parameter int OUT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_a,
    input  logic [LANES*DW-1:0] in_b,
    input  logic                in_last,
    input  logic [ACC_W-1:0]    bias,
    input  logic [1:0]          mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_ovf
);

    localparam int PW  = 2 * DW;
    localparam int SW  = tree_w(DW, LANES);
    localparam int MSB = ACC_W - 1;

    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic                adv;
    logic [LANES*PW-1:0] prod;
    logic [SW-1:0]       tree_sum;

    logic                s1_valid_q;
    logic                s1_last_q;
    logic [1:0]          s1_mode_q;
    logic [ACC_W-1:0]    s1_bias_q;
    logic [LANES*PW-1:0] s1_prod_q;

    logic                s2_valid_q;
    logic                s2_last_q;
    logic [1:0]          s2_mode_q;
    logic [ACC_W-1:0]    s2_bias_q;
    logic [SW-1:0]       s2_sum_q;

    acc_state_e          state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                out_ovf_q, out_ovf_d;

    logic signed [SW-1:0]    sum_s;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] res;
    logic signed [ACC_W-1:0] sat_r;
    logic                    ov_now;
    logic                    ovf_nxt;

    assign adv       = !out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    for (genvar i = 0; i < LANES; i++) begin : g_mul
        logic signed [DW-1:0] a_s;
        logic signed [DW-1:0] b_s;
        assign a_s = in_a[i*DW +: DW];
        assign b_s = in_b[i*DW +: DW];
        assign prod[i*PW +: PW] = PW'(a_s) * PW'(b_s);
    end

    // S1: register lane products and per-beat side info.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= '0;
            s1_bias_q  <= '0;
            s1_prod_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_last_q <= in_last;
                s1_mode_q <= mode;
                s1_bias_q <= bias;
                s1_prod_q <= prod;
            end
        end
    end

    mlp_adder_tree #(
        .LANES (LANES),
        .IW    (PW),
        .OW    (SW)
    ) u_tree (
        .p_i   (s1_prod_q),
        .sum_o (tree_sum)
    );

    // S2: register the reduced beat sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_mode_q  <= '0;
            s2_bias_q  <= '0;
            s2_sum_q   <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_last_q <= s1_last_q;
                s2_mode_q <= s1_mode_q;
                s2_bias_q <= s1_bias_q;
                s2_sum_q  <= tree_sum;
            end
        end
    end

    // S3: accumulate, track wrap, post-process and emit on last beat.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        sum_s   = s2_sum_q;
        base    = (state_q == FIRST) ? s2_bias_q : acc_q;
        addend  = ACC_W'(sum_s);
        acc_nxt = base + addend;
        ov_now  = (base[MSB] == addend[MSB]) &&
                  (acc_nxt[MSB] != base[MSB]);
        ovf_nxt = ((state_q == MID) & ovf_q) | ov_now;

        res = acc_nxt;
        if (s2_mode_q[MODE_RELU] && res[MSB]) begin
            res = '0;
        end
        sat_r = res;
        if (s2_mode_q[MODE_SAT] && (OUT_W < ACC_W)) begin
            if ($signed({res[MSB], res}) > SAT_MAX) begin
                sat_r = SAT_MAX[ACC_W-1:0];
            end else if ($signed({res[MSB], res}) < SAT_MIN) begin
                sat_r = SAT_MIN[ACC_W-1:0];
            end
        end

        if (adv) begin
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                acc_d = acc_nxt;
                ovf_d = ovf_nxt;
                if (s2_last_q) begin
                    state_d     = FIRST;
                    out_valid_d = 1'b1;
                    out_data_d  = sat_r[OUT_W-1:0];
                    out_ovf_d   = ovf_nxt;
                end else begin
                    state_d = MID;
                end
            end
        end
    end

    // S3 state, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FIRST;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mlp_dot_accel.sv
// Testbench for mlp_dot_accel: 32-bit and 16-bit output instances
// driven in lockstep, checked against a queue of modelled results.
module tb_mlp_dot_accel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] bias;
    logic [1:0]  mode;

    logic        in_ready;
    logic        in_ready16;
    logic        out_valid;
    logic        out_valid16;
    logic [31:0] out_data;
    logic [15:0] out_data16;
    logic        out_ovf;
    logic        out_ovf16;

    always #5 clk = ~clk;

    mlp_dot_accel #(
        .LANES(4), .DW(8), .ACC_W(32), .OUT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .bias(bias), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    mlp_dot_accel #(
        .LANES(4), .DW(8), .ACC_W(32), .OUT_W(16)
    ) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .bias(bias), .mode(mode),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_ovf(out_ovf16)
    );

    typedef struct {
        logic [31:0] d32;
        logic [15:0] d16;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    logic signed [31:0] m_acc;
    logic               m_first;
    logic               m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint dotp(input logic [31:0] a,
                                    input logic [31:0] b);
        longint s = 0;
        logic signed [7:0] ea, eb;
        for (int i = 0; i < 4; i++) begin
            ea = a[8*i +: 8];
            eb = b[8*i +: 8];
            s += longint'(ea) * longint'(eb);
        end
        return s;
    endfunction

    function automatic exp_t mk(input logic signed [31:0] w,
                                input logic [1:0] md, input logic ov);
        exp_t   e;
        longint r = longint'(w);
        if (md[0] && r < 0) r = 0;
        e.d32 = 32'(r);
        if (md[1]) begin
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
        end
        e.d16 = 16'(r);
        e.ovf = ov;
        return e;
    endfunction

    // One beat: wait (bounded) for acceptance, then update the model.
    task automatic beat(input logic [31:0] a, input logic [31:0] b,
                        input logic last, input logic [31:0] bv,
                        input logic [1:0] md);
        logic               ok;
        logic signed [31:0] bs;
        logic signed [31:0] w;
        longint             base, ex;
        in_a = a; in_b = b; in_last = last; bias = bv; mode = md;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            out_ready = 1'b1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 32'(ok), 32'd1);
        end else begin
            bs    = bv;
            base  = m_first ? longint'(bs) : longint'(m_acc);
            ex    = base + dotp(a, b);
            w     = 32'(ex);
            m_ovf = (m_first ? 1'b0 : m_ovf) | (ex != longint'(w));
            m_acc = w;
            m_first = last;
            if (last) q.push_back(mk(w, md, m_ovf));
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_a = $urandom; in_b = $urandom;
            bias = $urandom; in_last = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: every completed handshake consumes one expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("data32", out_data, e.d32);
                chk("ovf32", 32'(out_ovf), 32'(e.ovf));
                chk("valid16", 32'(out_valid16), 32'd1);
                chk("data16", 32'(out_data16), 32'(e.d16));
                chk("ovf16", 32'(out_ovf16), 32'(e.ovf));
            end
        end
    end

    initial begin
        logic       seen;
        int         len;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; in_a = '0; in_b = '0; bias = '0; mode = '0;
        m_acc = '0; m_first = 1'b1; m_ovf = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single beat and latency
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b1, 32'd3, 2'b00);
        @(negedge clk);
        @(negedge clk);
        chk("lat_before", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_at3", 32'(out_valid), 32'd1);
        drain();

        // three-beat vector, bias on later beats ignored
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 32'd3, 2'b01);
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 32'd99, 2'b01);
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b1, 32'd77, 2'b00);
        drain();

        // negative result, with and without ReLU, back to back
        beat(32'hF6F6F6F6, 32'h0A0A0A0A, 1'b1, 32'd0, 2'b00);
        beat(32'hF6F6F6F6, 32'h0A0A0A0A, 1'b1, 32'd0, 2'b01);
        drain();

        // saturation positive and negative, truncation
        beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0, 32'd0, 2'b00);
        beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 32'd0, 2'b10);
        beat(32'h80808080, 32'h7F7F7F7F, 1'b1, 32'd0, 2'b10);
        beat(32'h80808080, 32'h7F7F7F7F, 1'b1, 32'd0, 2'b00);
        drain();

        // accumulator wrap sets ovf, next vector clears it
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b1, 32'h7FFFFF00, 2'b00);
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b1, 32'd3, 2'b00);
        drain();

        // stall: result held, input blocked, then released
        out_ready = 1'b0;
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b1, 32'd3, 2'b00);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("stall_pending", 32'(seen), 32'd1);
        in_a = 32'h01020304; in_b = 32'h01010101;
        in_last = 1'b1; bias = 32'd5; mode = 2'b00; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_data", out_data, 32'd403);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        beat(32'h01020304, 32'h01010101, 1'b1, 32'd5, 2'b00);
        drain();

        // random vectors with bubbles and backpressure
        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                beat($urandom, $urandom, 1'(k == len - 1),
                     $urandom, 2'($urandom));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        out_ready = 1'b1;
        drain();

        // reset mid-vector discards the partial sum
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 32'd3, 2'b00);
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 32'd3, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data", out_data, 32'd0);
        chk("mrst_ovf", 32'(out_ovf), 32'd0);
        chk("mrst_data16", 32'(out_data16), 32'd0);
        m_acc = '0; m_first = 1'b1; m_ovf = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b1, 32'd3, 2'b00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
